niosii_system_sysid_checker: RTL and testbench

NIOSII_SYSTEM_SYSID_CHECKER -- requirements
Module: niosII_system_sysid_checker

---
 rtl/niosii_system_sysid_checker_pkg.sv | 13 +
 rtl/niosii_system_sysid_checker.sv | 132 +++++++++++++
 tb/tb_niosii_system_sysid_checker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared constants for the sysid checker: FSM state encoding and stall counter width.
package niosii_system_sysid_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RD_ID  = 2'd1,
      ST_RD_TS  = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   localparam int unsigned STALL_W = 16;

endpackage

// File: rtl/niosii_system_sysid_checker.sv
// Reads the sysid slave's ID and timestamp words over Avalon-MM and compares them
// against the expected build values, with a per-read waitrequest timeout.
module niosii_system_sysid_checker
   import niosii_system_sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1427239117,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   // Timeout fires on the stall cycle that would bring the count to TIMEOUT_CYCLES.
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

   state_e               state_q, state_d;
   logic [STALL_W-1:0]   stall_q, stall_d;
   logic                 avm_read_q, avm_read_d;
   logic                 avm_address_q, avm_address_d;
   logic                 id_ok_q, id_ok_d;
   logic                 ts_ok_q, ts_ok_d;
   logic                 timeout_q, timeout_d;
   logic [31:0]          captured_id_q, captured_id_d;
   logic [31:0]          captured_ts_q, captured_ts_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         stall_q       <= '0;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         captured_id_q <= '0;
         captured_ts_q <= '0;
      end else begin
         state_q       <= state_d;
         stall_q       <= stall_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
         captured_id_q <= captured_id_d;
         captured_ts_q <= captured_ts_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      stall_d       = stall_q;
      id_ok_d       = id_ok_q;
      ts_ok_d       = ts_ok_q;
      timeout_d     = timeout_q;
      captured_id_d = captured_id_q;
      captured_ts_d = captured_ts_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d       = ST_RD_ID;
               stall_d       = '0;
               id_ok_d       = 1'b0;
               ts_ok_d       = 1'b0;
               timeout_d     = 1'b0;
               captured_id_d = '0;
               captured_ts_d = '0;
            end
         end
         ST_RD_ID: begin
            if (!avm_waitrequest) begin
               captured_id_d = avm_readdata;
               id_ok_d       = (avm_readdata == EXPECTED_ID);
               stall_d       = '0;
               state_d       = ST_RD_TS;
            end else if (stall_q == STALL_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_FINISH;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
         ST_RD_TS: begin
            if (!avm_waitrequest) begin
               captured_ts_d = avm_readdata;
               ts_ok_d       = (avm_readdata == EXPECTED_TS);
               state_d       = ST_FINISH;
            end else if (stall_q == STALL_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_FINISH;
            end else begin
               stall_d = stall_q + 1'b1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Bus strobes are registered from the next state so they are stable for the whole read.
      avm_read_d    = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
      avm_address_d = (state_d == ST_RD_TS);
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FINISH);
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign captured_id = captured_id_q;
   assign captured_ts = captured_ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the sysid checker: behavioural sysid slave with programmable stalls.
module tb_niosii_system_sysid_checker;

   localparam logic [31:0] TS_GOOD = 32'd1427239117;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] captured_id, captured_ts;

   always #5 clock = ~clock;

   niosii_system_sysid_checker #(
      .EXPECTED_ID   (32'd0),
      .EXPECTED_TS   (TS_GOOD),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_readdata   (avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .busy           (busy),
      .done           (done),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout        (timeout),
      .captured_id    (captured_id),
      .captured_ts    (captured_ts)
   );

   // Slave model: stalls each read for a programmed number of cycles.
   logic [31:0] id_word = 32'd0;
   logic [31:0] ts_word = TS_GOOD;
   int          id_stall = 0;
   int          ts_stall = 0;
   int          cnt = 0;

   assign avm_waitrequest = avm_read && (cnt < (avm_address ? ts_stall : id_stall));
   assign avm_readdata    = avm_address ? ts_word : id_word;

   always @(posedge clock) begin
      if (!avm_read || !avm_waitrequest) cnt <= 0;
      else                               cnt <= cnt + 1;
   end

   // Monitor: done pulses, timestamp-read presence, strobe stability under stall.
   int   done_cnt = 0;
   int   viol_cnt = 0;
   logic addr1_seen = 1'b0;
   logic prev_wait = 1'b0, prev_read = 1'b0, prev_addr = 1'b0;

   always @(negedge clock) begin
      if (done) done_cnt++;
      if (avm_read && avm_address) addr1_seen = 1'b1;
      if (reset_n && prev_wait && !done && (avm_read !== prev_read || avm_address !== prev_addr))
         viol_cnt++;
      prev_wait = avm_read && avm_waitrequest;
      prev_read = avm_read;
      prev_addr = avm_address;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] id_word;
      logic [31:0] ts_word;
      int          id_stall;
      int          ts_stall;
      int          exp_lat;
      logic        exp_id_ok;
      logic        exp_ts_ok;
      logic        exp_to;
      logic [31:0] exp_cap_id;
      logic [31:0] exp_cap_ts;
      logic        exp_addr1;
   } vec_t;

   vec_t vecs[8];

   task automatic clear_mon();
      done_cnt   = 0;
      viol_cnt   = 0;
      addr1_seen = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      string p;
      p = $sformatf("v%0d", idx);
      id_word  = v.id_word;
      ts_word  = v.ts_word;
      id_stall = v.id_stall;
      ts_stall = v.ts_stall;
      @(negedge clock);
      clear_mon();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      chk({p, ".latency"}, lat, v.exp_lat);
      chk({p, ".busy_in_finish"}, busy, 1'b1);
      chk({p, ".id_ok"}, id_ok, v.exp_id_ok);
      chk({p, ".ts_ok"}, ts_ok, v.exp_ts_ok);
      chk({p, ".timeout"}, timeout, v.exp_to);
      chk({p, ".captured_id"}, captured_id, v.exp_cap_id);
      chk({p, ".captured_ts"}, captured_ts, v.exp_cap_ts);
      @(negedge clock);
      #1;
      chk({p, ".done_after"}, done, 1'b0);
      chk({p, ".busy_after"}, busy, 1'b0);
      chk({p, ".read_after"}, avm_read, 1'b0);
      chk({p, ".done_pulses"}, done_cnt, 1);
      chk({p, ".strobe_stable"}, viol_cnt, 0);
      chk({p, ".addr1_read"}, addr1_seen, v.exp_addr1);
   endtask

   initial begin
      int lat;
      //           id_word        ts_word        ids  tss  lat idok tsok to  cap_id         cap_ts         a1
      vecs[0] = '{32'd0,        TS_GOOD,        0,   0,   3, 1'b1, 1'b1, 1'b0, 32'd0,        TS_GOOD,        1'b1};
      vecs[1] = '{32'h00000001, TS_GOOD,        0,   0,   3, 1'b0, 1'b1, 1'b0, 32'h00000001, TS_GOOD,        1'b1};
      vecs[2] = '{32'd0,        32'h5511F0CC,   0,   0,   3, 1'b1, 1'b0, 1'b0, 32'd0,        32'h5511F0CC,   1'b1};
      vecs[3] = '{32'h80000000, 32'hD511F0CD,   0,   0,   3, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'hD511F0CD,   1'b1};
      vecs[4] = '{32'd0,        TS_GOOD,        4,   4,  11, 1'b1, 1'b1, 1'b0, 32'd0,        TS_GOOD,        1'b1};
      vecs[5] = '{32'd0,        TS_GOOD,        7,   7,  17, 1'b1, 1'b1, 1'b0, 32'd0,        TS_GOOD,        1'b1};
      vecs[6] = '{32'd0,        TS_GOOD,      100,   0,   9, 1'b0, 1'b0, 1'b1, 32'd0,        32'd0,          1'b0};
      vecs[7] = '{32'd0,        TS_GOOD,        0, 100,  10, 1'b1, 1'b0, 1'b1, 32'd0,        32'd0,          1'b1};

      // Reset state
      @(negedge clock);
      chk("rst.read", avm_read, 1'b0);
      chk("rst.addr", avm_address, 1'b0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.flags", {id_ok, ts_ok, timeout}, 3'b000);
      chk("rst.cap_id", captured_id, 32'd0);
      chk("rst.cap_ts", captured_ts, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset during timestamp stall
      id_word  = 32'd0;
      ts_word  = TS_GOOD;
      id_stall = 0;
      ts_stall = 100;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      chk("mid.pre_read", {avm_read, avm_address}, 2'b11);
      chk("mid.pre_id_ok", id_ok, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid.read_drop", avm_read, 1'b0);
      chk("mid.busy", busy, 1'b0);
      chk("mid.flags", {id_ok, ts_ok, timeout, done}, 4'b0000);
      chk("mid.cap_id", captured_id, 32'd0);
      @(negedge clock);
      chk("mid.held_idle", {busy, avm_read}, 2'b00);
      reset_n = 1'b1;
      run_vec(8, vecs[0]);

      // start pulses while busy and in FINISH are ignored
      @(negedge clock);
      clear_mon();
      start = 1'b1;
      @(negedge clock);
      chk("ign.rd_id", {busy, avm_read, avm_address}, 3'b110);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("ign.finish", done, 1'b1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      #1;
      chk("ign.done_pulses", done_cnt, 1);
      chk("ign.idle", busy, 1'b0);
      chk("ign.flags", {id_ok, ts_ok, timeout}, 3'b110);

      // start in the IDLE cycle right after done begins a new check
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         @(negedge clock);
         lat++;
      end
      chk("b2b.lat1", lat, 3);
      @(negedge clock);
      chk("b2b.idle", busy, 1'b0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("b2b.restart", {busy, avm_read, avm_address}, 3'b110);
      repeat (3) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
